// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline stage register for one datapath stage
// boundary. It holds a DATA_W-bit packed payload. Inputs are flush (a
// synchronous squash) and downstream backpressure, which stalls the stage.
// A saturating stall-cycle counter is kept for performance debug.
//
// Build option (macro PIPE_STAGE_SKID_EN):
//   defined   - two-entry skid buffer; in_ready comes from a flop, so there
//               is no combinational path from out_ready; occupancy is 0..2
//   undefined - main register only; in_ready = !out_valid | out_ready
//               (combinational); occupancy is 0..1
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   flush      synchronous squash of all held entries (highest priority)
//   in_valid   upstream payload valid
//   in_ready   stage accepts payload this cycle
//   in_data    upstream payload
//   out_valid  payload presented downstream
//   out_ready  downstream accepts payload this cycle
//   out_data   downstream payload (the main register)
//   occupancy  number of entries held
//   stall_cnt  count of cycles with out_valid & !out_ready; saturates, and
//              only RST clears it
module pipe_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // The state encoding is the occupancy count itself.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic              w_load_main_in;
    logic [CNT_W-1:0]  r_stall_cnt;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;
    logic              w_load_main_skid;
    logic              w_load_skid;
`endif

    // Next-state and load selects
    always_comb begin
        w_state_nxt    = r_state;
        w_load_main_in = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
`endif
        case (r_state)
            S_EMPTY: begin
                if (in_valid) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = S_ONE;
                end
            end
            S_ONE: begin
                if (out_ready) begin
                    if (in_valid) w_load_main_in = 1'b1;
                    else          w_state_nxt    = S_EMPTY;
                end
`ifdef PIPE_STAGE_SKID_EN
                // Downstream is stalled, so the new beat goes behind main.
                else if (in_valid) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = S_TWO;
                end
`endif
            end
            S_TWO: begin
`ifdef PIPE_STAGE_SKID_EN
                // The skid entry moves up only after main has left, which
                // keeps the beats in order.
                if (out_ready) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = S_ONE;
                end
`else
                w_state_nxt = S_EMPTY;
`endif
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // Flush overrides every transition. If the main entry is handed
        // out in the same cycle, it still counts as taken downstream.
        if (flush) w_state_nxt = S_EMPTY;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush)               r_main <= '0;
            else if (w_load_main_in) r_main <= in_data;
`ifdef PIPE_STAGE_SKID_EN
            else if (w_load_main_skid) r_main <= r_skid;
`endif
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (flush)            r_skid <= '0;
            else if (w_load_skid) r_skid <= in_data;
            // in_ready is registered: a second entry is still free unless
            // the next state is full.
            r_in_ready <= (w_state_nxt != S_TWO);
        end
    end

    assign in_ready  = r_in_ready;
    assign occupancy = r_state;
`else
    logic w_unused_state_msb;
    assign w_unused_state_msb = r_state[1];

    assign in_ready  = (r_state == S_EMPTY) | out_ready;
    assign occupancy = {1'b0, r_state[0]};
`endif

    // The stall counter holds at all-ones. Flush does not clear it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = (r_state != S_EMPTY);
    assign out_data  = r_main;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage.sv
module tb_pipe_stage;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    pipe_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_tot  = 0;

    // Model: a FIFO of held payloads, with the capacity set by the build.
    logic [DW-1:0] q[$];
    logic [DW-1:0] emitted[$];
    int            m_stall = 0;

    function automatic bit m_in_ready();
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return q.size() == 0 || out_ready;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(posedge CLK or posedge RST) begin
        bit mv;
        bit mr;
        if (RST) begin
            q.delete();
            emitted.delete();
            m_stall = 0;
        end else begin
            mv = q.size() > 0;
            mr = m_in_ready();
            if (mv && !out_ready && m_stall < SAT) m_stall++;
            if (mv && out_ready) emitted.push_back(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && mr) q.push_back(in_data);
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            if (q.size() > 0) chk("out_data", 64'(out_data), 64'(q[0]));
        end
    end

    task automatic cyc(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
        in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        in_valid = 0; in_data = '0; out_ready = 0; flush = 0;
        RST = 1;
        repeat (2) @(posedge CLK);
        #1 RST = 0;
    endtask

    logic [31:0] pv;
    logic [31:0] pr;
    bit          saw55;

    initial begin
        #2;
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Streaming, no bubbles
        cyc(1, 32'h11, 1, 0); chk("stream_d0", 64'(out_data), 64'h11); chk("stream_v0", 64'(out_valid), 64'd1);
        cyc(1, 32'h22, 1, 0); chk("stream_d1", 64'(out_data), 64'h22);
        cyc(1, 32'h33, 1, 0); chk("stream_d2", 64'(out_data), 64'h33);
        cyc(0, 32'h0, 1, 0);  chk("stream_end", 64'(out_valid), 64'd0);
        chk("stream_cnt", 64'(emitted.size()), 64'd3);
        if (emitted.size() == 3) begin
            chk("stream_o0", 64'(emitted[0]), 64'h11);
            chk("stream_o2", 64'(emitted[2]), 64'h33);
        end

        // Backpressure
        do_reset();
`ifdef PIPE_STAGE_SKID_EN
        cyc(1, 32'hA, 0, 0); chk("bp_main", 64'(out_data), 64'hA); chk("bp_occ1", 64'(occupancy), 64'd1);
        cyc(1, 32'hB, 0, 0); chk("bp_occ2", 64'(occupancy), 64'd2); chk("bp_rdy0", 64'(in_ready), 64'd0);
        cyc(1, 32'hC, 0, 0); chk("bp_hold", 64'(out_data), 64'hA); chk("bp_stall", 64'(stall_cnt), 64'd2);
        cyc(1, 32'hC, 1, 0); chk("bp_rel0", 64'(out_data), 64'hB); chk("bp_rel_occ", 64'(occupancy), 64'd1);
        cyc(1, 32'hC, 1, 0); chk("bp_rel1", 64'(out_data), 64'hC);
        cyc(0, 32'h0, 1, 0); chk("bp_empty", 64'(occupancy), 64'd0);
        chk("bp_cnt", 64'(emitted.size()), 64'd3);
        if (emitted.size() == 3) begin
            chk("bp_o0", 64'(emitted[0]), 64'hA);
            chk("bp_o1", 64'(emitted[1]), 64'hB);
            chk("bp_o2", 64'(emitted[2]), 64'hC);
        end
        chk("bp_stall_end", 64'(stall_cnt), 64'd2);
`else
        cyc(1, 32'hA, 0, 0); chk("bp_main", 64'(out_data), 64'hA);
        in_valid = 1; in_data = 32'hB; out_ready = 0;
        #1 chk("bp_comb_rdy0", 64'(in_ready), 64'd0);
        cyc(1, 32'hB, 0, 0); chk("bp_hold", 64'(out_data), 64'hA); chk("bp_occ1", 64'(occupancy), 64'd1);
        chk("bp_stall", 64'(stall_cnt), 64'd1);
        out_ready = 1;
        #1 chk("bp_comb_rdy1", 64'(in_ready), 64'd1);
        cyc(1, 32'hB, 1, 0); chk("bp_next", 64'(out_data), 64'hB);
        cyc(0, 32'h0, 1, 0); chk("bp_empty", 64'(occupancy), 64'd0);
        chk("bp_cnt", 64'(emitted.size()), 64'd2);
`endif

        // Flush with a same-cycle input that must be dropped
        do_reset();
        cyc(1, 32'hA, 0, 0);
`ifdef PIPE_STAGE_SKID_EN
        cyc(1, 32'hB, 0, 0); chk("fl_pre_occ", 64'(occupancy), 64'd2);
        chk("fl_pre_stall", 64'(stall_cnt), 64'd1);
        cyc(1, 32'h55, 1, 1);
        chk("fl_stall", 64'(stall_cnt), 64'd1);
`else
        chk("fl_pre_occ", 64'(occupancy), 64'd1);
        cyc(1, 32'h55, 1, 1);
        chk("fl_stall", 64'(stall_cnt), 64'd0);
`endif
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_rdy", 64'(in_ready), 64'd1);
        chk("fl_data", 64'(out_data), 64'd0);
        cyc(0, 32'h0, 1, 0);
        cyc(0, 32'h0, 1, 0);
        saw55 = 0;
        foreach (emitted[i]) if (emitted[i] == 32'h55) saw55 = 1;
        chk("fl_no55", 64'(saw55), 64'd0);
        chk("fl_emitA", 64'(emitted.size()), 64'd1);

        // Mixed valid/ready pattern, checked cycle by cycle against the model
        do_reset();
        pv = 32'b1011_1110_0111_1101_1011_0110_1111_0101;
        pr = 32'b0110_0011_1010_1100_1111_0001_0110_1011;
        for (int i = 0; i < 32; i++) cyc(pv[i], 32'h100 + i, pr[i], i == 20);
        repeat (3) cyc(0, 32'h0, 1, 0);
        chk("mix_drained", 64'(occupancy), 64'd0);

        // Stall counter saturation
        do_reset();
        cyc(1, 32'h77, 0, 0);
        repeat (20) cyc(0, 32'h0, 0, 0);
        chk("sat_cnt", 64'(stall_cnt), 64'd15);
        chk("sat_data", 64'(out_data), 64'h77);
`ifdef PIPE_STAGE_SKID_EN
        cyc(1, 32'h88, 0, 0);
        chk("sat_occ2", 64'(occupancy), 64'd2);
`endif

        // Asynchronous reset mid-cycle while full
        in_valid = 0; out_ready = 0;
        #2 RST = 1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_occ", 64'(occupancy), 64'd0);
        chk("arst_stall", 64'(stall_cnt), 64'd0);
        chk("arst_rdy", 64'(in_ready), 64'd1);
        @(posedge CLK); #1 RST = 0;
        cyc(1, 32'h99, 1, 0); chk("arst_after", 64'(out_data), 64'h99);
        cyc(0, 32'h0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
